// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if: core request/response channel plus word-wide memory bus.
// master = the sequencer; slave = the core and memory around it.
interface mem_access_sequencer_if #(parameter int ADDR_W = 32);
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_fault;
  logic [31:0]       resp_rdata;
  logic              mem_valid, mem_ready, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;
  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_fault, resp_rdata, mem_valid, mem_write, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_fault, resp_rdata, mem_valid, mem_write, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: turns byte/half/word load-store requests into word-aligned bus beats,
// splitting word-crossing accesses in two and reassembling/extending load data.
module mem_access_sequencer #(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input logic clk,
  input logic reset_n,
  mem_access_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RESP, FAULT} state_t;
  state_t state, state_nx;
  logic              wr_q, sgn_q, split_q;
  logic [1:0]        sz_q, off_q;
  logic [7:0]        be_q;
  logic [63:0]       wd_q;
  logic [ADDR_W-1:0] a0_q;
  logic [31:0]       r0_q;
  logic [2:0]        nb;
  logic [1:0]        off;
  logic              split_in, accept, b0, b1;
  logic [31:0]       r0, r1, lo, ext;
  assign off      = bus.req_addr[1:0];
  assign nb       = bus.req_size == 2'd0 ? 3'd1 : bus.req_size == 2'd1 ? 3'd2 : 3'd4;
  assign split_in = {1'b0, off} + nb > 3'd4;
  assign accept   = bus.req_valid && state == IDLE;
  assign b0       = state == BEAT0;
  assign b1       = state == BEAT1;
  // Final-beat data is taken live from the bus so the response can be registered on the handshake edge.
  assign r0  = b0 ? bus.mem_rdata : r0_q;
  assign r1  = b1 ? bus.mem_rdata : 32'd0;
  assign lo  = (r0 >> {off_q, 3'b000}) | (off_q == 2'd0 ? 32'd0 : r1 << (6'd32 - {1'b0, off_q, 3'b000}));
  assign ext = sz_q == 2'd0 ? {{24{sgn_q & lo[7]}}, lo[7:0]} :
               sz_q == 2'd1 ? {{16{sgn_q & lo[15]}}, lo[15:0]} : lo;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !bus.req_valid ? IDLE : (split_in && !SPLIT_EN) ? FAULT : BEAT0;
      BEAT0:   state_nx = !bus.mem_ready ? BEAT0 : split_q ? BEAT1 : RESP;
      BEAT1:   state_nx = bus.mem_ready ? RESP : BEAT1;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.mem_valid = b0 || b1;
    bus.mem_write = (b0 || b1) && wr_q;
    bus.mem_addr  = b0 ? a0_q : b1 ? a0_q + ADDR_W'(4) : '0;
    bus.mem_be    = b0 ? be_q[3:0] : b1 ? be_q[7:4] : 4'd0;
    bus.mem_wdata = b0 ? wd_q[31:0] : b1 ? wd_q[63:32] : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q           <= 1'b0;
      sgn_q          <= 1'b0;
      split_q        <= 1'b0;
      sz_q           <= 2'd0;
      off_q          <= 2'd0;
      be_q           <= 8'd0;
      wd_q           <= 64'd0;
      a0_q           <= '0;
      r0_q           <= 32'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_rdata <= 32'd0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_write;
        sgn_q   <= bus.req_signed;
        split_q <= split_in;
        sz_q    <= bus.req_size;
        off_q   <= off;
        be_q    <= ((8'd1 << nb) - 8'd1) << off;
        wd_q    <= {32'd0, bus.req_wdata} << {off, 3'b000};
        a0_q    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
      end
      if (b0 && bus.mem_ready) r0_q <= bus.mem_rdata;
      bus.resp_valid <= state_nx == RESP || state_nx == FAULT;
      bus.resp_fault <= state_nx == FAULT;
      bus.resp_rdata <= (state_nx == RESP && !wr_q) ? ext : 32'd0;
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed checks of beat generation, split, fault, back-pressure and reset.
module tb_mem_access_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cmp = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mem_access_sequencer_if #(.ADDR_W(32)) s1 ();
  mem_access_sequencer_if #(.ADDR_W(32)) s0 ();
  mem_access_sequencer #(.ADDR_W(32), .SPLIT_EN(1'b1)) u1 (.clk(clk), .reset_n(reset_n), .bus(s1.master));
  mem_access_sequencer #(.ADDR_W(32), .SPLIT_EN(1'b0)) u0 (.clk(clk), .reset_n(reset_n), .bus(s0.master));

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!s1.req_ready && n < 20) begin @(negedge clk); n++; end
    cmp++; if (n == 20) begin bad++; $display("FAIL issue_timeout: req_ready got 0 want 1"); end
    s1.req_valid = 1'b1; s1.req_write = w; s1.req_size = sz; s1.req_signed = sg; s1.req_addr = a; s1.req_wdata = d;
    @(negedge clk);
    s1.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    cmp++; if (s1.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s1.req_ready); end
    cmp++; if (s1.mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid: got %b want 0", s1.mem_valid); end
    cmp++; if (s1.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", s1.resp_valid); end
    cmp++; if (s1.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", s1.mem_addr); end
    cmp++; if (s1.mem_be !== 4'h0) begin bad++; $display("FAIL reset_mem_be: got %b want 0000", s1.mem_be); end
    cmp++; if (s1.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", s1.resp_rdata); end
    cmp++; if (s0.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_s0: got %b want 1", s0.req_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_byte;
    issue(1'b1, 2'd0, 1'b0, 32'h1002, 32'h000000A5);
    cmp++; if (s1.mem_valid !== 1'b1) begin bad++; $display("FAIL sb_valid: got %b want 1", s1.mem_valid); end
    cmp++; if (s1.mem_write !== 1'b1) begin bad++; $display("FAIL sb_write: got %b want 1", s1.mem_write); end
    cmp++; if (s1.mem_addr !== 32'h1000) begin bad++; $display("FAIL sb_addr: got %h want 00001000", s1.mem_addr); end
    cmp++; if (s1.mem_be !== 4'b0100) begin bad++; $display("FAIL sb_be: got %b want 0100", s1.mem_be); end
    cmp++; if (s1.mem_wdata !== 32'h00A50000) begin bad++; $display("FAIL sb_wdata: got %h want 00a50000", s1.mem_wdata); end
    cmp++; if (s1.req_ready !== 1'b0) begin bad++; $display("FAIL sb_busy: got %b want 0", s1.req_ready); end
    cmp++; if (s1.resp_valid !== 1'b0) begin bad++; $display("FAIL sb_early_resp: got %b want 0", s1.resp_valid); end
    @(negedge clk);
    cmp++; if (s1.resp_valid !== 1'b1) begin bad++; $display("FAIL sb_resp: got %b want 1", s1.resp_valid); end
    cmp++; if (s1.resp_fault !== 1'b0) begin bad++; $display("FAIL sb_fault: got %b want 0", s1.resp_fault); end
    cmp++; if (s1.resp_rdata !== 32'h0) begin bad++; $display("FAIL sb_rdata: got %h want 0", s1.resp_rdata); end
    cmp++; if (s1.mem_valid !== 1'b0) begin bad++; $display("FAIL sb_resp_overlap: got %b want 0", s1.mem_valid); end
    @(negedge clk);
    cmp++; if (s1.req_ready !== 1'b1) begin bad++; $display("FAIL sb_turnaround: got %b want 1", s1.req_ready); end
    cmp++; if (s1.resp_valid !== 1'b0) begin bad++; $display("FAIL sb_resp_pulse: got %b want 0", s1.resp_valid); end
  endtask

  task automatic test_load_half;
    s1.mem_rdata = 32'h80011234;
    issue(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0);
    cmp++; if (s1.mem_be !== 4'b1100) begin bad++; $display("FAIL lh_be: got %b want 1100", s1.mem_be); end
    cmp++; if (s1.mem_write !== 1'b0) begin bad++; $display("FAIL lh_write: got %b want 0", s1.mem_write); end
    cmp++; if (s1.mem_addr !== 32'h2000) begin bad++; $display("FAIL lh_addr: got %h want 00002000", s1.mem_addr); end
    @(negedge clk);
    cmp++; if (s1.resp_valid !== 1'b1) begin bad++; $display("FAIL lh_resp: got %b want 1", s1.resp_valid); end
    cmp++; if (s1.resp_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_signed: got %h want ffff8001", s1.resp_rdata); end
    @(negedge clk);
    issue(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0);
    @(negedge clk);
    cmp++; if (s1.resp_rdata !== 32'h00008001) begin bad++; $display("FAIL lh_unsigned: got %h want 00008001", s1.resp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_split_store;
    issue(1'b1, 2'd2, 1'b0, 32'h3003, 32'h11223344);
    cmp++; if (s1.mem_addr !== 32'h3000) begin bad++; $display("FAIL ss_addr0: got %h want 00003000", s1.mem_addr); end
    cmp++; if (s1.mem_be !== 4'b1000) begin bad++; $display("FAIL ss_be0: got %b want 1000", s1.mem_be); end
    cmp++; if (s1.mem_wdata !== 32'h44000000) begin bad++; $display("FAIL ss_data0: got %h want 44000000", s1.mem_wdata); end
    @(negedge clk);
    cmp++; if (s1.mem_valid !== 1'b1) begin bad++; $display("FAIL ss_valid1: got %b want 1", s1.mem_valid); end
    cmp++; if (s1.mem_addr !== 32'h3004) begin bad++; $display("FAIL ss_addr1: got %h want 00003004", s1.mem_addr); end
    cmp++; if (s1.mem_be !== 4'b0111) begin bad++; $display("FAIL ss_be1: got %b want 0111", s1.mem_be); end
    cmp++; if (s1.mem_wdata !== 32'h00112233) begin bad++; $display("FAIL ss_data1: got %h want 00112233", s1.mem_wdata); end
    @(negedge clk);
    cmp++; if (s1.resp_valid !== 1'b1) begin bad++; $display("FAIL ss_resp: got %b want 1", s1.resp_valid); end
    cmp++; if (s1.mem_valid !== 1'b0) begin bad++; $display("FAIL ss_done: got %b want 0", s1.mem_valid); end
    @(negedge clk);
    cmp++; if (s1.req_ready !== 1'b1) begin bad++; $display("FAIL ss_turnaround: got %b want 1", s1.req_ready); end
  endtask

  task automatic test_split_load;
    s1.mem_rdata = 32'hDDCCBBAA;
    issue(1'b0, 2'd2, 1'b0, 32'h4001, 32'h0);
    cmp++; if (s1.mem_be !== 4'b1110) begin bad++; $display("FAIL sl_be0: got %b want 1110", s1.mem_be); end
    @(negedge clk);
    cmp++; if (s1.mem_addr !== 32'h4004) begin bad++; $display("FAIL sl_addr1: got %h want 00004004", s1.mem_addr); end
    cmp++; if (s1.mem_be !== 4'b0001) begin bad++; $display("FAIL sl_be1: got %b want 0001", s1.mem_be); end
    s1.mem_rdata = 32'h000000EE;
    @(negedge clk);
    cmp++; if (s1.resp_valid !== 1'b1) begin bad++; $display("FAIL sl_resp: got %b want 1", s1.resp_valid); end
    cmp++; if (s1.resp_rdata !== 32'hEEDDCCBB) begin bad++; $display("FAIL sl_rdata: got %h want eeddccbb", s1.resp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_split_disabled;
    s0.mem_rdata = 32'hFFFFFFFF;
    s0.req_valid = 1'b1; s0.req_write = 1'b0; s0.req_size = 2'd2; s0.req_signed = 1'b0; s0.req_addr = 32'h4001;
    @(negedge clk);
    s0.req_valid = 1'b0;
    cmp++; if (s0.mem_valid !== 1'b0) begin bad++; $display("FAIL sd_mem_valid: got %b want 0", s0.mem_valid); end
    cmp++; if (s0.resp_valid !== 1'b1) begin bad++; $display("FAIL sd_resp: got %b want 1", s0.resp_valid); end
    cmp++; if (s0.resp_fault !== 1'b1) begin bad++; $display("FAIL sd_fault: got %b want 1", s0.resp_fault); end
    cmp++; if (s0.resp_rdata !== 32'h0) begin bad++; $display("FAIL sd_rdata: got %h want 0", s0.resp_rdata); end
    @(negedge clk);
    cmp++; if (s0.mem_valid !== 1'b0) begin bad++; $display("FAIL sd_no_beat: got %b want 0", s0.mem_valid); end
    cmp++; if (s0.resp_valid !== 1'b0) begin bad++; $display("FAIL sd_pulse: got %b want 0", s0.resp_valid); end
    cmp++; if (s0.req_ready !== 1'b1) begin bad++; $display("FAIL sd_ready: got %b want 1", s0.req_ready); end
    s0.req_valid = 1'b1; s0.req_addr = 32'h4000;
    @(negedge clk);
    s0.req_valid = 1'b0;
    cmp++; if (s0.mem_be !== 4'b1111) begin bad++; $display("FAIL sd_aligned_be: got %b want 1111", s0.mem_be); end
    @(negedge clk);
    cmp++; if (s0.resp_fault !== 1'b0) begin bad++; $display("FAIL sd_aligned_fault: got %b want 0", s0.resp_fault); end
    cmp++; if (s0.resp_rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL sd_aligned_rdata: got %h want ffffffff", s0.resp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int resps = 0;
    issue(1'b1, 2'd2, 1'b0, 32'h5002, 32'hCAFEBABE);
    cmp++; if (s1.mem_wdata !== 32'hBABE0000) begin bad++; $display("FAIL bp_data0: got %h want babe0000", s1.mem_wdata); end
    @(negedge clk);
    s1.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmp++; if (s1.mem_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, s1.mem_valid); end
      cmp++; if (s1.mem_addr !== 32'h5004) begin bad++; $display("FAIL bp_addr[%0d]: got %h want 00005004", i, s1.mem_addr); end
      cmp++; if (s1.mem_be !== 4'b0011) begin bad++; $display("FAIL bp_be[%0d]: got %b want 0011", i, s1.mem_be); end
      cmp++; if (s1.mem_wdata !== 32'h0000CAFE) begin bad++; $display("FAIL bp_data[%0d]: got %h want 0000cafe", i, s1.mem_wdata); end
      cmp++; if (s1.req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, s1.req_ready); end
      resps += int'(s1.resp_valid);
      if (i < 5) @(negedge clk);
    end
    s1.mem_ready = 1'b1;
    repeat (3) begin @(negedge clk); resps += int'(s1.resp_valid); end
    cmp++; if (resps != 1) begin bad++; $display("FAIL bp_resp_count: got %0d want 1", resps); end
  endtask

  task automatic test_reset_mid;
    s1.mem_rdata = 32'h89ABCDEF;
    issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
    cmp++; if (s1.mem_valid !== 1'b1) begin bad++; $display("FAIL rm_beat: got %b want 1", s1.mem_valid); end
    #2 reset_n = 1'b0;
    #1;
    cmp++; if (s1.mem_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", s1.mem_valid); end
    cmp++; if (s1.req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", s1.req_ready); end
    cmp++; if (s1.mem_addr !== 32'h0) begin bad++; $display("FAIL rm_addr: got %h want 0", s1.mem_addr); end
    cmp++; if (s1.mem_be !== 4'h0) begin bad++; $display("FAIL rm_be: got %b want 0000", s1.mem_be); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cmp++; if (s1.resp_valid !== 1'b0) begin bad++; $display("FAIL rm_stale: got %b want 0", s1.resp_valid); end
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    cmp++; if (s1.mem_addr !== 32'h0 || s1.mem_be !== 4'b1111) begin bad++; $display("FAIL rm_new_beat: got %h/%b want 00000000/1111", s1.mem_addr, s1.mem_be); end
    @(negedge clk);
    cmp++; if (s1.resp_valid !== 1'b1) begin bad++; $display("FAIL rm_new_resp: got %b want 1", s1.resp_valid); end
    cmp++; if (s1.resp_rdata !== 32'h89ABCDEF) begin bad++; $display("FAIL rm_new_rdata: got %h want 89abcdef", s1.resp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    s1.req_valid = 1'b0; s1.req_write = 1'b0; s1.req_size = 2'd0; s1.req_signed = 1'b0; s1.req_addr = '0; s1.req_wdata = '0;
    s1.mem_ready = 1'b1; s1.mem_rdata = '0;
    s0.req_valid = 1'b0; s0.req_write = 1'b0; s0.req_size = 2'd0; s0.req_signed = 1'b0; s0.req_addr = '0; s0.req_wdata = '0;
    s0.mem_ready = 1'b1; s0.mem_rdata = '0;
    test_reset;
    test_store_byte;
    test_load_half;
    test_split_store;
    test_split_load;
    test_split_disabled;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sits between the core's load/store stage and the word-wide data memory port.
- Accepts one byte/half/word request at a time and generates word-aligned bus beats with per-lane byte enables.
- Splits accesses that cross a word boundary into two beats.
- Lane-aligns store data, then reassembles and sign/zero-extends load data.

Parameters:
- ADDR_W, 32: address width; bits [1:0] are the byte offset.
- SPLIT_EN, 1: 1 = split word-crossing accesses into two beats; 0 = reject them with resp_fault and no memory access.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  sequencer can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = word
- req_signed  input  1  sign-extend load result
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_fault  output  1  valid with resp_valid; misaligned access rejected
- resp_rdata  output  32  extended load data; 0 for stores and faults
- mem_valid  output  1  bus beat request
- mem_ready  input  1  beat accepted; mem_rdata is valid in the same cycle
- mem_write  output  1  beat is a write
- mem_addr  output  ADDR_W  word address with [1:0] = 0
- mem_be  output  4  byte enables; bit i = byte lane i (bits 8i+7:8i)
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  read data

Behaviour:
- Reset (async, reset_n low): state IDLE. req_ready=1. All other outputs 0. Any in-flight transaction is abandoned with no response.
- Byte count: n = 1, 2, 4 for size 0, 1, 2/3. Offset: off = req_addr[1:0].
- Split condition: off + n > 4, i.e. half at off 3, or word at off 1–3.
- Enable mask: m = ((1<<n)-1) << off, 8 bits. Beat0 be = m[3:0]. Beat1 be = m[7:4].
- Store data: W = {32'b0, req_wdata} << (8*off), 64 bits. Beat0 data = W[31:0]. Beat1 data = W[63:32].
- Addresses: beat0 = {addr[ADDR_W-1:2], 2'b00}; beat1 = beat0 + 4, wrapping at 2^ADDR_W.
- Request capture: all request fields are registered on req_valid & req_ready.
- States:
  - IDLE: req_ready=1. On accept, go to BEAT0, or to FAULT if split is needed and SPLIT_EN=0.
  - BEAT0: mem_valid=1, beat0 fields driven. On mem_ready, capture mem_rdata as R0, then go to BEAT1 if split, else RESP.
  - BEAT1: mem_valid=1, beat1 fields driven. On mem_ready, capture R1, go to RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE.
    - Load: resp_rdata = ({R1, R0} >> 8*off), truncated to n bytes, then sign-extended if req_signed, else zero-extended.
    - R1 = 0 when there is no second beat.
  - FAULT: resp_valid=1, resp_fault=1, resp_rdata=0 for one cycle, then IDLE. No mem_valid is issued.
- Outputs are registered, with these exceptions:
  - mem_valid, mem_addr, mem_be, mem_wdata and mem_write are driven from registered state.
  - req_ready = (state == IDLE).
- Bus hold: while mem_valid=1 and mem_ready=0, all mem_* outputs stay stable. mem_be, mem_wdata and mem_addr are 0 outside BEAT states.
- Loads drive mem_be with the same mask as stores; memory may ignore it.
- Latency, aligned access with mem_ready tied 1:
  - accept at edge T
  - mem_valid high in cycle T..T+1
  - resp_valid high in the cycle after the mem handshake
  - req_ready returns one cycle later
  - total of 3 cycles from accept to next accept
- A split access adds one beat (4-cycle turnaround with mem_ready=1).
- No request is accepted while busy. req_valid is ignored outside IDLE.
- resp_valid is never asserted in the same cycle as mem_valid.

Test Plan:
- Store byte: addr 0x1002, size 0, wdata 0xA5 -> one beat, mem_addr 0x1000, be 0100, mem_wdata 0x00A50000; resp_valid one cycle later, rdata 0.
- Signed load half: addr 0x2002, mem_rdata 0x8001xxxx -> be 1100; resp_rdata 0xFFFF8001. Same with req_signed=0 -> 0x00008001.
- Split store word: addr 0x3003, wdata 0x11223344, SPLIT_EN=1 -> beat0 addr 0x3000 be 1000 data 0x44000000; beat1 addr 0x3004 be 0111 data 0x00112233.
- Split load word, off 1: reads 0xDDCCBBAA then 0x00000EE -> resp_rdata 0xEEDDCCBB. Rerun with SPLIT_EN=0 -> no mem_valid, resp_fault=1, rdata 0.
- Back-pressure: hold mem_ready=0 for 5 cycles mid-BEAT1 -> mem_* outputs unchanged, req_ready stays 0, exactly one response.
- Reset mid-operation: drop reset_n during BEAT0 -> outputs 0 immediately and req_ready=1. After release, a new aligned word load at 0x0 completes normally; no stale resp_valid.
